// File: rtl/lsu_mem_stage.sv
// Load/store unit between execute and a byte-addressed little-endian data SRAM.
// One request in flight: latch, one SRAM access cycle, then an optional load response.
module lsu_mem_stage #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [REG_W-1:0]  req_rd,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_w_en,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [REG_W-1:0]  rsp_rd,
    output logic              rsp_err,
    output logic              fault
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [REG_W-1:0] rd_q;
    logic [31:0]      rsp_data_q;
    logic [REG_W-1:0] rsp_rd_q;
    logic             rsp_err_q;

    logic             accept;
    logic             in_access;
    logic [ADDR_W:0]  size_m1;
    logic [ADDR_W:0]  end_addr;
    logic             hi_bad;
    logic             range_bad;
    logic             funct3_bad;
    logic             store_bad;
    logic             fault_c;
    logic [3:0]       size_mask;
    logic [31:0]      load_data;

    assign accept    = req_valid && req_ready;
    assign in_access = (state_q == ACCESS);

    // Last byte touched, with a carry bit so accesses past the top never wrap to 0.
    always_comb begin
        size_m1 = '0;
        unique case (funct3_q[1:0])
            2'b00:   size_m1[1:0] = 2'd0;
            2'b01:   size_m1[1:0] = 2'd1;
            default: size_m1[1:0] = 2'd3;
        endcase
    end

    assign end_addr   = {1'b0, addr_q[ADDR_W-1:0]} + size_m1;
    assign hi_bad     = |addr_q[31:ADDR_W];
    assign range_bad  = end_addr[ADDR_W];
    assign funct3_bad = (funct3_q == 3'b011) || (funct3_q == 3'b110) || (funct3_q == 3'b111);
    assign store_bad  = we_q && funct3_q[2];
    assign fault_c    = hi_bad || range_bad || funct3_bad || store_bad;

    always_comb begin
        unique case (funct3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    always_comb begin
        load_data = mem_read_data;
        case (funct3_q)
            3'b000:  load_data = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
            3'b100:  load_data = {24'd0, mem_read_data[7:0]};
            3'b001:  load_data = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
            3'b101:  load_data = {16'd0, mem_read_data[15:0]};
            default: load_data = mem_read_data;
        endcase
        if (fault_c) begin
            load_data = 32'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  state_d = we_q ? IDLE : RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rd_q       <= '0;
            rsp_data_q <= 32'd0;
            rsp_rd_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rd_q     <= req_rd;
            end
            if (in_access && !we_q) begin
                rsp_data_q <= load_data;
                rsp_rd_q   <= rd_q;
                rsp_err_q  <= fault_c;
            end
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign mem_address    = addr_q[ADDR_W-1:0];
    assign mem_write_data = wdata_q;
    assign mem_w_en       = (in_access && we_q && !fault_c) ? size_mask : 4'b0000;
    assign fault          = in_access && fault_c;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_data       = rsp_data_q;
    assign rsp_rd         = rsp_rd_q;
    assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a behavioural 64 KiB byte SRAM.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [15:0] mem_address;
    logic [3:0]  mem_w_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        fault;

    int compared = 0;
    int mismatched = 0;

    lsu_mem_stage #(.ADDR_W(16), .REG_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .mem_address    (mem_address),
        .mem_w_en       (mem_w_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_rd         (rsp_rd),
        .rsp_err        (rsp_err),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    // SRAM: combinational read of addr..addr+3, byte-masked write on the rising edge.
    logic [7:0]  mem [0:65535];
    logic        init_done = 1'b0;
    wire  [15:0] a1 = mem_address + 16'd1;
    wire  [15:0] a2 = mem_address + 16'd2;
    wire  [15:0] a3 = mem_address + 16'd3;
    assign mem_read_data = {mem[a3], mem[a2], mem[a1], mem[mem_address]};

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
            mem[16'h0300] <= 8'h11;
            mem[16'h0303] <= 8'h33;
            mem[16'hFFFC] <= 8'h78;
            mem[16'hFFFD] <= 8'h56;
            mem[16'hFFFE] <= 8'h34;
            mem[16'hFFFF] <= 8'h12;
            init_done <= 1'b1;
        end else begin
            if (mem_w_en[0]) mem[mem_address] <= mem_write_data[7:0];
            if (mem_w_en[1]) mem[a1] <= mem_write_data[15:8];
            if (mem_w_en[2]) mem[a2] <= mem_write_data[23:16];
            if (mem_w_en[3]) mem[a3] <= mem_write_data[31:24];
        end
    end

    task automatic step;
        @(negedge clk);
    endtask

    // Present a request, wait for acceptance, and return what the ACCESS cycle showed.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        output logic [3:0] wen, output logic flt, output logic [15:0] ad);
        int n = 0;
        while (!req_ready && n < 20) begin
            step;
            n++;
        end
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL send_timeout: req_ready=%b required 1", req_ready);
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        step;
        wen = mem_w_en;
        flt = fault;
        ad  = mem_address;
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic v, output logic [31:0] d, output logic [4:0] rd,
                           output logic err);
        step;
        v   = rsp_valid;
        d   = rsp_data;
        rd  = rsp_rd;
        err = rsp_err;
        step;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step;
        step;
        rst_n = 1'b1;
        step;
        compared++;
        if ({req_ready, rsp_valid, rsp_err, fault} !== 4'b1000) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b required 1000", {req_ready, rsp_valid, rsp_err, fault});
        end
        compared++;
        if ({rsp_data, rsp_rd} !== 37'd0) begin
            mismatched++;
            $display("FAIL reset_rsp: data=%h rd=%0d required 0", rsp_data, rsp_rd);
        end
        compared++;
        if (mem_w_en !== 4'b0000 || mem_address !== 16'd0 || mem_write_data !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_mem: wen=%b addr=%h wdata=%h required 0", mem_w_en,
                     mem_address, mem_write_data);
        end
    endtask

    task automatic test_word;
        logic [3:0] wen; logic flt; logic [15:0] ad;
        logic v, err; logic [31:0] d; logic [4:0] rd;
        send(1'b1, 3'b010, 32'h0100, 32'hA1B2C3D4, 5'd0, wen, flt, ad);
        compared++;
        if (wen !== 4'b1111 || flt !== 1'b0 || ad !== 16'h0100 || mem_write_data !== 32'hA1B2C3D4) begin
            mismatched++;
            $display("FAIL sw_access: wen=%b fault=%b addr=%h wdata=%h required 1111 0 0100 a1b2c3d4",
                     wen, flt, ad, mem_write_data);
        end
        step;
        compared++;
        if (mem_w_en !== 4'b0000 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL sw_after: wen=%b ready=%b required 0000 1", mem_w_en, req_ready);
        end
        send(1'b0, 3'b010, 32'h0100, 32'h0, 5'd7, wen, flt, ad);
        compared++;
        if (wen !== 4'b0000 || flt !== 1'b0) begin
            mismatched++;
            $display("FAIL lw_access: wen=%b fault=%b required 0000 0", wen, flt);
        end
        get_rsp(v, d, rd, err);
        compared++;
        if ({v, d, rd, err} !== {1'b1, 32'hA1B2C3D4, 5'd7, 1'b0}) begin
            mismatched++;
            $display("FAIL lw_rsp: v=%b data=%h rd=%0d err=%b required 1 a1b2c3d4 7 0", v, d, rd, err);
        end
    endtask

    task automatic test_byte;
        logic [3:0] wen; logic flt; logic [15:0] ad;
        logic v, err; logic [31:0] d; logic [4:0] rd;
        send(1'b1, 3'b000, 32'h0200, 32'h00000080, 5'd0, wen, flt, ad);
        compared++;
        if (wen !== 4'b0001) begin
            mismatched++;
            $display("FAIL sb_wen: got %b required 0001", wen);
        end
        step;
        send(1'b0, 3'b000, 32'h0200, 32'h0, 5'd3, wen, flt, ad);
        get_rsp(v, d, rd, err);
        compared++;
        if ({v, d, rd, err} !== {1'b1, 32'hFFFFFF80, 5'd3, 1'b0}) begin
            mismatched++;
            $display("FAIL lb_rsp: v=%b data=%h rd=%0d err=%b required 1 ffffff80 3 0", v, d, rd, err);
        end
        send(1'b0, 3'b100, 32'h0200, 32'h0, 5'd4, wen, flt, ad);
        get_rsp(v, d, rd, err);
        compared++;
        if ({v, d, rd, err} !== {1'b1, 32'h00000080, 5'd4, 1'b0}) begin
            mismatched++;
            $display("FAIL lbu_rsp: v=%b data=%h rd=%0d err=%b required 1 00000080 4 0", v, d, rd, err);
        end
    endtask

    task automatic test_half;
        logic [3:0] wen; logic flt; logic [15:0] ad;
        logic v, err; logic [31:0] d; logic [4:0] rd;
        send(1'b1, 3'b001, 32'h0301, 32'h00008001, 5'd0, wen, flt, ad);
        compared++;
        if (wen !== 4'b0011 || flt !== 1'b0) begin
            mismatched++;
            $display("FAIL sh_wen: wen=%b fault=%b required 0011 0", wen, flt);
        end
        step;
        compared++;
        if ({mem[16'h0300], mem[16'h0301], mem[16'h0302], mem[16'h0303]} !== 32'h11018033) begin
            mismatched++;
            $display("FAIL sh_bytes: got %h required 11018033",
                     {mem[16'h0300], mem[16'h0301], mem[16'h0302], mem[16'h0303]});
        end
        send(1'b0, 3'b001, 32'h0301, 32'h0, 5'd10, wen, flt, ad);
        get_rsp(v, d, rd, err);
        compared++;
        if ({v, d, rd, err} !== {1'b1, 32'hFFFF8001, 5'd10, 1'b0}) begin
            mismatched++;
            $display("FAIL lh_rsp: v=%b data=%h rd=%0d err=%b required 1 ffff8001 10 0", v, d, rd, err);
        end
        send(1'b0, 3'b101, 32'h0301, 32'h0, 5'd11, wen, flt, ad);
        get_rsp(v, d, rd, err);
        compared++;
        if ({v, d, rd, err} !== {1'b1, 32'h00008001, 5'd11, 1'b0}) begin
            mismatched++;
            $display("FAIL lhu_rsp: v=%b data=%h rd=%0d err=%b required 1 00008001 11 0", v, d, rd, err);
        end
    endtask

    task automatic test_fault;
        logic [3:0] wen; logic flt; logic [15:0] ad;
        logic v, err; logic [31:0] d; logic [4:0] rd;
        send(1'b0, 3'b010, 32'h0000FFFE, 32'h0, 5'd9, wen, flt, ad);
        compared++;
        if (wen !== 4'b0000 || flt !== 1'b1) begin
            mismatched++;
            $display("FAIL lw_top_access: wen=%b fault=%b required 0000 1", wen, flt);
        end
        get_rsp(v, d, rd, err);
        compared++;
        if ({v, d, rd, err} !== {1'b1, 32'h0, 5'd9, 1'b1}) begin
            mismatched++;
            $display("FAIL lw_top_rsp: v=%b data=%h rd=%0d err=%b required 1 0 9 1", v, d, rd, err);
        end
        send(1'b1, 3'b010, 32'h00010000, 32'hDEADBEEF, 5'd0, wen, flt, ad);
        compared++;
        if (wen !== 4'b0000 || flt !== 1'b1) begin
            mismatched++;
            $display("FAIL sw_high_access: wen=%b fault=%b required 0000 1", wen, flt);
        end
        step;
        compared++;
        if (fault !== 1'b0 || mem[16'h0000] !== 8'h00) begin
            mismatched++;
            $display("FAIL sw_high_after: fault=%b mem0=%h required 0 00", fault, mem[16'h0000]);
        end
        send(1'b1, 3'b100, 32'h0400, 32'h000000AA, 5'd0, wen, flt, ad);
        compared++;
        if (wen !== 4'b0000 || flt !== 1'b1) begin
            mismatched++;
            $display("FAIL sbu_access: wen=%b fault=%b required 0000 1", wen, flt);
        end
        step;
        compared++;
        if (mem[16'h0400] !== 8'h00) begin
            mismatched++;
            $display("FAIL sbu_mem: got %h required 00", mem[16'h0400]);
        end
        send(1'b0, 3'b010, 32'h0000FFFC, 32'h0, 5'd13, wen, flt, ad);
        compared++;
        if (flt !== 1'b0) begin
            mismatched++;
            $display("FAIL lw_fffc_fault: got %b required 0", flt);
        end
        get_rsp(v, d, rd, err);
        compared++;
        if ({v, d, rd, err} !== {1'b1, 32'h12345678, 5'd13, 1'b0}) begin
            mismatched++;
            $display("FAIL lw_fffc_rsp: v=%b data=%h rd=%0d err=%b required 1 12345678 13 0", v, d, rd, err);
        end
    endtask

    task automatic test_stall;
        logic [3:0] wen; logic flt; logic [15:0] ad;
        int bad = 0;
        rsp_ready = 1'b0;
        send(1'b0, 3'b010, 32'h0100, 32'h0, 5'd12, wen, flt, ad);
        // Hold a second request while the response is back-pressured.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b100;
        req_addr   = 32'h0200;
        req_rd     = 5'd5;
        for (int i = 0; i < 5; i++) begin
            step;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hA1B2C3D4 || rsp_rd !== 5'd12 ||
                req_ready !== 1'b0) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL stall_hold: %0d bad cycles required 0 (v=%b data=%h ready=%b)",
                     bad, rsp_valid, rsp_data, req_ready);
        end
        rsp_ready = 1'b1;
        step;
        compared++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_release: v=%b ready=%b required 0 1", rsp_valid, req_ready);
        end
        step;
        compared++;
        if (req_ready !== 1'b0 || mem_address !== 16'h0200) begin
            mismatched++;
            $display("FAIL stall_next_accept: ready=%b addr=%h required 0 0200", req_ready, mem_address);
        end
        req_valid = 1'b0;
        step;
        compared++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h00000080 || rsp_rd !== 5'd5) begin
            mismatched++;
            $display("FAIL stall_next_rsp: v=%b data=%h rd=%0d required 1 00000080 5",
                     rsp_valid, rsp_data, rsp_rd);
        end
        step;
    endtask

    task automatic test_reset_mid;
        logic [3:0] wen; logic flt; logic [15:0] ad;
        send(1'b1, 3'b010, 32'h0500, 32'h55667788, 5'd0, wen, flt, ad);
        compared++;
        if (wen !== 4'b1111) begin
            mismatched++;
            $display("FAIL rst_mid_pre: wen=%b required 1111", wen);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (mem_w_en !== 4'b0000 || mem_address !== 16'd0 || mem_write_data !== 32'd0 ||
            rsp_valid !== 1'b0 || fault !== 1'b0 || rsp_data !== 32'd0) begin
            mismatched++;
            $display("FAIL rst_mid_outputs: wen=%b addr=%h wdata=%h v=%b fault=%b required all 0",
                     mem_w_en, mem_address, mem_write_data, rsp_valid, fault);
        end
        step;
        compared++;
        if ({mem[16'h0500], mem[16'h0501], mem[16'h0502], mem[16'h0503]} !== 32'h0) begin
            mismatched++;
            $display("FAIL rst_mid_mem: got %h required 00000000",
                     {mem[16'h0500], mem[16'h0501], mem[16'h0502], mem[16'h0503]});
        end
        rst_n = 1'b1;
        step;
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid_ready: got %b required 1", req_ready);
        end
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_fault;
        test_stall;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
